// File: rtl/bch_31_seq_encoder.sv
// bch_31_seq_encoder: sequential, handshaked BCH(31,21) t=2 systematic encoder.
// An LFSR divides msg(x)*x^10 by GEN_POLY, folding BITS_PER_CYCLE message bits per clock.
// The output is {msg[20:0], parity[9:0]}.
// Optional feature macro: BCH_ENC_SERIAL_OUT_EN adds the ser_bit/ser_valid serial stream
// and a DRAIN state. That option needs BITS_PER_CYCLE == 1.
module bch_31_seq_encoder #(
  parameter int         BITS_PER_CYCLE = 1,
  parameter logic [10:0] GEN_POLY      = 11'h769
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] msg_i,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [30:0] codeword_o,
  output logic        cw_valid,
  input  logic        cw_ready
`ifdef BCH_ENC_SERIAL_OUT_EN
  ,
  output logic        ser_bit,
  output logic        ser_valid
`endif
);

  localparam int unsigned BPC     = BITS_PER_CYCLE;
  localparam int          N_SHIFT = 21 / BITS_PER_CYCLE;
  localparam int          CW      = $clog2(N_SHIFT + 1);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 3 ||
        BITS_PER_CYCLE == 7 || BITS_PER_CYCLE == 21)) begin : g_bad_bpc
    $error("bch_31_seq_encoder: BITS_PER_CYCLE must be one of 1, 3, 7, 21");
  end

`ifdef BCH_ENC_SERIAL_OUT_EN
  if (BITS_PER_CYCLE != 1) begin : g_bad_serial
    $error("bch_31_seq_encoder: serial output requires BITS_PER_CYCLE == 1");
  end
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef BCH_ENC_SERIAL_OUT_EN
    DRAIN,
`endif
    DONE
  } state_t;

  state_t          state, next_state;
  logic [20:0]     msg_r;
  logic [20:0]     msg_sh;
  logic [9:0]      lfsr;
  logic [9:0]      lfsr_next;
  logic [CW-1:0]   count;
  logic            shift_last;
  logic [9:0]      parity;
`ifdef BCH_ENC_SERIAL_OUT_EN
  logic [9:0]      par_r;
  logic            drain_last;
  assign drain_last = (count == CW'(9));
  // The LFSR is drained for the serial stream, so the codeword uses a parity copy taken on SHIFT exit.
  assign parity     = par_r;
`else
  assign parity     = lfsr;
`endif

  assign shift_last = (count == CW'(N_SHIFT - 1));

  // LFSR division step: fold the next BPC message bits in, MSB first.
  always_comb begin
    lfsr_next = lfsr;
    for (int unsigned j = 0; j < BPC; j++) begin
      if (lfsr_next[9] ^ msg_sh[20 - j])
        lfsr_next = {lfsr_next[8:0], 1'b0} ^ GEN_POLY[9:0];
      else
        lfsr_next = {lfsr_next[8:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode and handshake/output generation.
  always_comb begin
    next_state = state;
    msg_ready  = 1'b0;
    cw_valid   = 1'b0;
    codeword_o = '0;
`ifdef BCH_ENC_SERIAL_OUT_EN
    ser_bit    = 1'b0;
    ser_valid  = 1'b0;
`endif
    case (state)
      IDLE: begin
        msg_ready = rst;
        if (msg_valid) next_state = SHIFT;
      end
      SHIFT: begin
`ifdef BCH_ENC_SERIAL_OUT_EN
        ser_bit   = msg_sh[20];
        ser_valid = 1'b1;
        if (shift_last) next_state = DRAIN;
`else
        if (shift_last) next_state = DONE;
`endif
      end
`ifdef BCH_ENC_SERIAL_OUT_EN
      DRAIN: begin
        ser_bit   = lfsr[9];
        ser_valid = 1'b1;
        if (drain_last) next_state = DONE;
      end
`endif
      DONE: begin
        cw_valid   = 1'b1;
        codeword_o = {msg_r, parity};
        if (cw_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: message capture, LFSR division and cycle counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      msg_r  <= '0;
      msg_sh <= '0;
      lfsr   <= '0;
      count  <= '0;
`ifdef BCH_ENC_SERIAL_OUT_EN
      par_r  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (msg_valid) begin
            msg_r  <= msg_i;
            msg_sh <= msg_i;
            lfsr   <= '0;
            count  <= '0;
          end
        end
        SHIFT: begin
          lfsr   <= lfsr_next;
          msg_sh <= msg_sh << BPC;
`ifdef BCH_ENC_SERIAL_OUT_EN
          // The counter is reused to time the 10-cycle parity drain.
          if (shift_last) begin
            count <= '0;
            par_r <= lfsr_next;
          end else begin
            count <= count + 1'b1;
          end
`else
          count  <= count + 1'b1;
`endif
        end
`ifdef BCH_ENC_SERIAL_OUT_EN
        DRAIN: begin
          lfsr  <= {lfsr[8:0], 1'b0};
          count <= count + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
